// File: rtl/layered_objects_mux.sv
// N-layer priority compositor for the VGA path: per-layer enable and colour key,
// 2-stage pipeline with aligned valid, per-pixel collision flag and per-frame collision latch.

module layered_objects_mux_layer #(
  parameter int               RGB_W       = 8,
  parameter int               KEY_EN      = 1,
  parameter logic [RGB_W-1:0] TRANSPARENT = '1
) (
  input  logic             req,
  input  logic             en,
  input  logic [RGB_W-1:0] rgb,
  output logic             eff
);
  logic keyed;

  assign keyed = (KEY_EN != 0) && (rgb == TRANSPARENT);
  assign eff   = req & en & ~keyed;
endmodule

module layered_objects_mux #(
  parameter  int               NUM_LAYERS  = 4,
  parameter  int               RGB_W       = 8,
  parameter  int               KEY_EN      = 1,
  parameter  logic [RGB_W-1:0] TRANSPARENT = 8'hFF,
  localparam int               IDX_W       = $clog2(NUM_LAYERS + 1)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        pixelValid,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       drawingRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] layersRGB,
  input  logic [RGB_W-1:0]            backGroundRGB,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  output logic [RGB_W-1:0]            RGBOut,
  output logic                        RGBValid,
  output logic [IDX_W-1:0]            topLayer,
  output logic                        collisionPulse,
  output logic [NUM_LAYERS-1:0]       collisionFrame
);
  localparam int STAGES = 2;

  logic [NUM_LAYERS-1:0][RGB_W-1:0] rgb_in;
  logic [NUM_LAYERS-1:0]            eff_in;

  logic [NUM_LAYERS-1:0][RGB_W-1:0] rgb_s1;
  logic [NUM_LAYERS-1:0]            eff_s1;
  logic [RGB_W-1:0]                 bg_s1;
  logic                             sof_s1;
  logic [STAGES:1]                  vld_pipe;

  logic [NUM_LAYERS-1:0]            acc;
  logic [IDX_W-1:0]                 win_idx;
  logic [RGB_W-1:0]                 win_rgb;
  logic [IDX_W-1:0]                 cnt;
  logic                             multi;
  logic [NUM_LAYERS-1:0]            hit;

  assign rgb_in = layersRGB;

  genvar g;
  generate
    for (g = 0; g < NUM_LAYERS; g++) begin : g_layer
      layered_objects_mux_layer #(
        .RGB_W       (RGB_W),
        .KEY_EN      (KEY_EN),
        .TRANSPARENT (TRANSPARENT)
      ) u_layer (
        .req (drawingRequest[g]),
        .en  (layerEnable[g]),
        .rgb (rgb_in[g]),
        .eff (eff_in[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_s1   <= '0;
      eff_s1   <= '0;
      bg_s1    <= '0;
      sof_s1   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      rgb_s1   <= rgb_in;
      eff_s1   <= eff_in;
      bg_s1    <= backGroundRGB;
      sof_s1   <= startOfFrame;
      vld_pipe <= {vld_pipe[STAGES-1:1], pixelValid};
    end
  end

  // Scan from the lowest priority up so the lowest effective index is left standing.
  always_comb begin
    win_idx = IDX_W'(NUM_LAYERS);
    win_rgb = bg_s1;
    cnt     = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff_s1[i]) begin
        win_idx = IDX_W'(i);
        win_rgb = rgb_s1[i];
      end
      cnt = cnt + IDX_W'(eff_s1[i]);
    end
    multi = vld_pipe[1] && (cnt > IDX_W'(1));
    hit   = multi ? eff_s1 : '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut         <= '0;
      RGBValid       <= 1'b0;
      topLayer       <= IDX_W'(NUM_LAYERS);
      collisionPulse <= 1'b0;
      acc            <= '0;
      collisionFrame <= '0;
    end else begin
      RGBValid       <= vld_pipe[1];
      collisionPulse <= multi;
      if (vld_pipe[1]) begin
        RGBOut   <= win_rgb;
        topLayer <= win_idx;
      end else begin
        RGBOut   <= '0;
        topLayer <= IDX_W'(NUM_LAYERS);
      end
      // The SOF pixel opens the new frame, so its hits seed the fresh accumulator.
      if (sof_s1) begin
        collisionFrame <= acc;
        acc            <= hit;
      end else begin
        acc <= acc | hit;
      end
    end
  end
endmodule

// File: tb/tb_layered_objects_mux.sv
// Randomized scoreboard bench for layered_objects_mux: keyed and unkeyed instances
// against a pixel-level reference model.

module tb_layered_objects_mux;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           resetN = 1'b0;
  logic           pixelValid = 1'b0;
  logic           startOfFrame = 1'b0;
  logic [N-1:0]   drawingRequest = '0;
  logic [N*W-1:0] layersRGB = '0;
  logic [W-1:0]   backGroundRGB = '0;
  logic [N-1:0]   layerEnable = '1;

  logic [W-1:0]   rgb_a, rgb_b;
  logic           vld_a, vld_b;
  logic [IW-1:0]  top_a, top_b;
  logic           pulse_a, pulse_b;
  logic [N-1:0]   cf_a, cf_b;

  always #5 clk = ~clk;

  layered_objects_mux #(.NUM_LAYERS(N), .RGB_W(W), .KEY_EN(1), .TRANSPARENT(8'hFF)) dut_a (
    .clk(clk), .resetN(resetN), .pixelValid(pixelValid), .startOfFrame(startOfFrame),
    .drawingRequest(drawingRequest), .layersRGB(layersRGB), .backGroundRGB(backGroundRGB),
    .layerEnable(layerEnable), .RGBOut(rgb_a), .RGBValid(vld_a), .topLayer(top_a),
    .collisionPulse(pulse_a), .collisionFrame(cf_a));

  layered_objects_mux #(.NUM_LAYERS(N), .RGB_W(W), .KEY_EN(0), .TRANSPARENT(8'hFF)) dut_b (
    .clk(clk), .resetN(resetN), .pixelValid(pixelValid), .startOfFrame(startOfFrame),
    .drawingRequest(drawingRequest), .layersRGB(layersRGB), .backGroundRGB(backGroundRGB),
    .layerEnable(layerEnable), .RGBOut(rgb_b), .RGBValid(vld_b), .topLayer(top_b),
    .collisionPulse(pulse_b), .collisionFrame(cf_b));

  typedef struct {
    int           due;
    logic [W-1:0] rgb;
    int           top;
    logic         vld;
    logic         pulse;
    logic [N-1:0] cf;
  } exp_t;

  exp_t         qa[$];
  exp_t         qb[$];
  logic [N-1:0] acc_m[2];
  logic [N-1:0] cf_m[2];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: k=0 models the keyed instance, k=1 the unkeyed one.
  function automatic exp_t model(input int k);
    exp_t         e;
    logic [N-1:0] eff;
    logic [N-1:0] hit;
    int           n;
    bit           found;
    for (int i = 0; i < N; i++)
      eff[i] = drawingRequest[i] && layerEnable[i] &&
               !(k == 0 && layersRGB[i*W +: W] == 8'hFF);
    n = $countones(eff);
    e.due = cyc + 2;
    e.vld = pixelValid;
    e.rgb = '0;
    e.top = N;
    e.pulse = 1'b0;
    if (pixelValid) begin
      e.rgb = backGroundRGB;
      found = 0;
      for (int i = 0; i < N; i++)
        if (!found && eff[i]) begin
          found = 1;
          e.top = i;
          e.rgb = layersRGB[i*W +: W];
        end
      e.pulse = (n >= 2);
    end
    hit = (pixelValid && n >= 2) ? eff : '0;
    if (startOfFrame) begin
      cf_m[k]  = acc_m[k];
      acc_m[k] = hit;
    end else begin
      acc_m[k] = acc_m[k] | hit;
    end
    e.cf = cf_m[k];
    return e;
  endfunction

  task automatic drive(input logic v, input logic sof, input logic [N-1:0] req,
                       input logic [N-1:0] en, input logic [N*W-1:0] rgbs, input logic [W-1:0] bg);
    @(posedge clk);
    #1;
    pixelValid     = v;
    startOfFrame   = sof;
    drawingRequest = req;
    layerEnable    = en;
    layersRGB      = rgbs;
    backGroundRGB  = bg;
    qa.push_back(model(0));
    qb.push_back(model(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    resetN = 1'b0;
    pixelValid = 1'b0;
    startOfFrame = 1'b0;
    qa.delete();
    qb.delete();
    for (int k = 0; k < 2; k++) begin
      acc_m[k] = '0;
      cf_m[k]  = '0;
    end
    #1;
    chk("reset_rgb", rgb_a, 0);
    chk("reset_vld", vld_a, 0);
    chk("reset_top", top_a, N);
    chk("reset_pulse", pulse_a, 0);
    chk("reset_cf", cf_a, 0);
    chk("reset_cf_b", cf_b, 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  always @(negedge clk) begin
    if (resetN) begin
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rgb", rgb_a, e.rgb);
        chk("a_top", top_a, e.top);
        chk("a_vld", vld_a, e.vld);
        chk("a_pulse", pulse_a, e.pulse);
        chk("a_cf", cf_a, e.cf);
      end
      while (qb.size() > 0 && qb[0].due <= cyc) begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rgb", rgb_b, e.rgb);
        chk("b_top", top_b, e.top);
        chk("b_vld", vld_b, e.vld);
        chk("b_pulse", pulse_b, e.pulse);
        chk("b_cf", cf_b, e.cf);
      end
    end
  end

  initial begin
    logic [N*W-1:0] rr;
    logic [N-1:0]   en;
    logic           v;
    logic           sof;
    acc_m[0] = '0; acc_m[1] = '0;
    cf_m[0]  = '0; cf_m[1]  = '0;
    do_reset();

    // Directed pixels from the block's worked examples.
    drive(1, 1, 4'b0110, 4'hF, {8'h00, 8'hE0, 8'h1C, 8'h00}, 8'h03);
    drive(1, 0, 4'b0001, 4'hF, {8'h00, 8'h00, 8'h00, 8'hFF}, 8'h03);
    drive(1, 0, 4'b1111, 4'b1100, {8'h44, 8'h33, 8'h22, 8'h11}, 8'h03);
    drive(1, 0, 4'b1111, 4'b1000, {8'h44, 8'h33, 8'h22, 8'h11}, 8'h03);
    // Frame A with a 0/2 overlap, frame B clean, then an idle SOF.
    drive(1, 1, 4'b0000, 4'hF, 32'h0, 8'h05);
    drive(1, 0, 4'b0101, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 0, 4'b0010, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 1, 4'b0001, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 0, 4'b1000, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 1, 4'b0000, 4'hF, 32'h0, 8'h05);
    // Blanking with all requests, back-to-back SOFs.
    drive(0, 0, 4'b1111, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(0, 0, 4'b1111, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 1, 4'b1100, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 1, 4'b0011, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 1, 4'b0000, 4'hF, 32'h0, 8'h05);
    // Collisions on 0 and 1, then reset mid-frame, post-reset hits on 2 and 3.
    drive(1, 0, 4'b0011, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 0, 4'b0011, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    do_reset();
    drive(1, 0, 4'b1100, 4'hF, {8'h01, 8'h02, 8'h03, 8'h04}, 8'h05);
    drive(1, 1, 4'b0000, 4'hF, 32'h0, 8'h05);
    drive(1, 0, 4'b0000, 4'hF, 32'h0, 8'h05);

    for (int it = 0; it < 2000; it++) begin
      if (it == 700 || it == 1400) do_reset();
      sof = (it % 16 == 0);
      v   = sof || ($urandom_range(0, 9) != 0);
      en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      for (int i = 0; i < N; i++)
        rr[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
      drive(v, sof, N'($urandom), en, rr, W'($urandom));
    end
    drive(0, 0, '0, '1, '0, '0);
    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained_a", qa.size(), 0);
    chk("queue_drained_b", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
